// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch unit with a small in-order instruction queue
//
// Purpose:
//   Issues one word-aligned read per cycle to a single-cycle-latency instruction
//   memory. Responses are buffered in a DEPTH-entry FIFO tagged with their
//   fetch address. Decode drains the FIFO through a valid/ready handshake.
//   A redirect from execute flushes the queue and restarts fetch at the target.
//
// Ports:
//   clk            in   1   clock, all state updates on the rising edge
//   reset          in   1   synchronous, active-high reset
//   imem_req       out  1   read request issued this cycle
//   imem_addr      out  32  word-aligned read address, valid with imem_req
//   imem_rdata     in   32  read data, valid the cycle after the request
//   redirect_valid in   1   branch/jump redirect from execute
//   redirect_pc    in   32  redirect target (low two bits ignored)
//   out_valid      out  1   queue head holds an instruction for decode
//   out_instr      out  32  head instruction word
//   out_pc         out  32  address of the head instruction
//   out_ready      in   1   decode accepts the head this cycle

module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // DEPTH at the widths of the occupancy sum and of the entry counter
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc_q,    fetch_pc_d;
    logic [CW-1:0] count_q,       count_d;
    logic          inflight_q,    inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,      wr_ptr_d;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [CW:0]   occupancy;
    logic          fetch_go;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;

    // Entries already held plus the response still on its way back. A pop in
    // the current cycle is deliberately not credited, so a response can never
    // arrive into a full queue.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

    assign fetch_go  = !reset && !redirect_valid && (occupancy < DEPTH_OCC);

    // A response returning during a redirect belongs to the old stream and is
    // dropped; one returning during reset is dropped as well.
    assign push      = inflight_q && !redirect_valid && !reset;

    assign out_valid = !reset && !redirect_valid && (count_q != '0);
    assign pop       = out_valid && out_ready;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req  = fetch_go;
    assign imem_addr = fetch_pc_q;

    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (redirect_valid) begin
            // Flush everything; no request goes out this cycle, so nothing
            // from the old stream can return next cycle either.
            fetch_pc_d = redirect_target;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (fetch_go) begin
                // Natural 32-bit wrap takes 0xFFFF_FFFC to 0x0000_0000.
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_pc_d = fetch_pc_q;
                inflight_d    = 1'b1;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers; reset overrides redirect and handshakes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    // The credit rule must make a push into a full queue impossible.
    a_no_push_when_full : assert property (@(posedge clk)
        !(push && (count_q == DEPTH_CNT)));

    a_count_in_range : assert property (@(posedge clk)
        count_q <= DEPTH_CNT);

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  instruction memory read request this cycle.
REQ-006 imem_addr  output  32  word-aligned read address, valid when imem_req=1.
REQ-007 imem_rdata  input  32  read data, valid exactly one cycle after the request.
REQ-008 redirect_valid  input  1  branch/jump redirect from execute.
REQ-009 redirect_pc  input  32  redirect target address.
REQ-010 out_valid  output  1  queue head holds a valid instruction for decode.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc  output  32  address of the head instruction.
REQ-013 out_ready  input  1  decode accepts the head this cycle.

Function
REQ-014 The block SHALL keep fetch_pc, count (0..DEPTH) and a one-bit inflight flag.
REQ-015 The block SHALL assert imem_req with imem_addr=fetch_pc when not in reset, redirect_valid=0, and count+inflight<DEPTH; pops in the same cycle are not credited.
REQ-016 On each issued request, fetch_pc SHALL advance by 4, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 A response SHALL be pushed at the end of the cycle after its request, with its request address as pc; earliest out_valid is two cycles after the request.
REQ-018 out_valid SHALL equal (count!=0) && !redirect_valid; out_instr/out_pc SHALL reflect the oldest entry.
REQ-019 A transfer SHALL occur when out_valid && out_ready; the head is popped at that edge.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve ordering.
REQ-021 The credit rule SHALL guarantee no push when full; a push at count=DEPTH is a design error (assertion).
REQ-022 out_ready with out_valid=0 SHALL have no effect.
REQ-023 On redirect_valid in cycle N: count->0, any response arriving in N+1 discarded, fetch_pc<=redirect_pc with bits [1:0] forced to 0, no request in N.
REQ-024 The first request after redirect SHALL issue in cycle N+1 at the redirect target; out_valid SHALL be 0 in N and N+1 and no earlier than N+3 high.
REQ-025 Back-to-back redirects SHALL each apply; the last one wins.
REQ-026 Steady state with out_ready=1 SHALL sustain one instruction per cycle.

Reset
REQ-027 While reset=1: imem_req=0, out_valid=0, count=0, inflight=0, fetch_pc=RESET_PC.
REQ-028 A response returning in the cycle after reset SHALL be discarded.
REQ-029 Reset SHALL take priority over redirect and handshakes in the same cycle.
REQ-030 The first request SHALL issue in the first cycle after reset deasserts, at RESET_PC.

Verification
REQ-031 Reset release, memory word[i]=i+100, out_ready=1 -> req at 0,4,8... one per cycle; out_valid two cycles after first req; (pc,instr)=(0,100),(4,101),(8,102) in order.
REQ-032 out_ready=0 for 10 cycles -> exactly 4 requests, count=4, imem_req low thereafter; raising out_ready drains 0,4,8,C then fetch resumes at 0x10.
REQ-033 Redirect to 0x40 while queue holds 3 entries and a request is in flight -> queue flushed, stale response dropped, next req 0x40, next delivered pc=0x40.
REQ-034 Redirect to 0x43 -> next req and delivered pc 0x40.
REQ-035 fetch_pc=0xFFFF_FFF8, free-run -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Reset asserted mid-stream with queue full and request in flight -> next cycle out_valid=0; after release first req at RESET_PC, no stale instruction delivered.
